// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled serial line to parallel bytes, with framing-error detection.
// Latency: 2 clk synchroniser, then the byte is ready about 9.5 bit periods after the start edge.
// Backpressure: none. Each good byte overwrites rx_dato_out whether or not it has been read.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   rx           raw serial line, idle high, asynchronous to clk
//   s_tick       one-clk pulse at OVERSAMPLE x baud
//   rx_dato_out  last correctly framed byte, held until the next good frame
//   rx_done      one-clk strobe, rx_dato_out updated this cycle
//   frame_err    one-clk strobe, stop bit sampled low and byte discarded
module uart_rx #(
  parameter int D_BIT      = 8,
  parameter int SB_TICK    = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             s_tick,
  output logic [D_BIT-1:0] rx_dato_out,
  output logic             rx_done,
  output logic             frame_err
);

  localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(D_BIT + 1);

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_FULL = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(D_BIT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic             sync1_q, sync2_q;
  logic             rx_s;
  logic [2:0]       state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [NW-1:0]    n_q, n_d;
  logic [D_BIT-1:0] b_q, b_d;
  logic [D_BIT-1:0] dato_q, dato_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;

  // Synchroniser resets to the idle-high level so reset release never looks like a start bit.
  assign rx_s = sync2_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dato_d  = dato_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Start edge is taken without waiting for a tick.
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_HALF) begin
            // Mid start bit: still low means a real start, high means a glitch.
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_FULL) begin
            s_d = '0;
            b_d = {rx_s, b_q[D_BIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            if (rx_s) begin
              dato_d  = b_q;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Hold off until the line returns high so a break is not seen as endless frames.
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dato_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dato_q  <= dato_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_dato_out = dato_q;
  assign rx_done     = done_q;
  assign frame_err   = ferr_q;

endmodule
